// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, ALU drive and response signals of the ALU op sequencer
interface alu_op_sequencer_if #(parameter int TAG_W = 4, parameter int CNT_W = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [1:0]       cmd_fun;
  logic [TAG_W-1:0] cmd_tag;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_fun;
  logic [7:0]       alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] err_count;
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, cmd_tag, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_tag, rsp_err,
           busy, op_count, err_count
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, cmd_tag, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_tag, rsp_err,
           busy, op_count, err_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues commands to a registered 4-bit ALU and returns tagged results
module alu_op_sequencer #(
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input logic CLK,
  input logic RST,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic accept, div0, done;
  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign div0   = bus.cmd_fun == 2'b11 && bus.cmd_b == 4'd0;
  assign done   = bus.rsp_valid & bus.rsp_ready;
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE  ? (accept ? (div0 ? RESP : DRIVE) : IDLE) :
          state == DRIVE ? WAIT :
          state == WAIT  ? (cnt == '0 ? RESP : WAIT) :
          (done ? IDLE : RESP);
  end
  // reset gates ready so nothing is accepted while RST is held
  always_comb begin
    bus.cmd_ready = state == IDLE && !RST;
    bus.rsp_valid = state == RESP;
    bus.busy      = state != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_fun   <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_tag   <= '0;
      bus.rsp_err   <= 1'b0;
      bus.op_count  <= '0;
      bus.err_count <= '0;
      cnt           <= '0;
    end else begin
      if (accept) begin
        bus.rsp_tag <= bus.cmd_tag;
        if (div0) begin
          bus.rsp_data <= 8'hFF;
          bus.rsp_err  <= 1'b1;
        end else begin
          bus.alu_a   <= bus.cmd_a;
          bus.alu_b   <= bus.cmd_b;
          bus.alu_fun <= bus.cmd_fun;
        end
      end
      if (state == DRIVE) cnt <= CW'(ALU_LAT - 1);
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          bus.rsp_data <= bus.alu_out;
          bus.rsp_err  <= 1'b0;
        end
      end
      if (done) begin
        bus.op_count  <= bus.op_count + 1'b1;
        bus.err_count <= bus.err_count + CNT_W'(bus.rsp_err);
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of the ALU op sequencer against a registered ALU model
module tb_alu_op_sequencer;
  logic clk = 0;
  logic rst = 1;
  int vecs = 0;
  int errs = 0;
  alu_op_sequencer_if #(.TAG_W(4), .CNT_W(8)) bus();
  alu_op_sequencer #(.TAG_W(4), .ALU_LAT(1), .CNT_W(8)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    bus.alu_out <= bus.alu_fun == 2'd0 ? 8'(bus.alu_a) + 8'(bus.alu_b) :
                   bus.alu_fun == 2'd1 ? 8'(bus.alu_a) - 8'(bus.alu_b) :
                   bus.alu_fun == 2'd2 ? 8'(bus.alu_a) * 8'(bus.alu_b) :
                   bus.alu_b == 4'd0 ? 8'hFF : 8'(bus.alu_a / bus.alu_b);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] fun,
                        input logic [3:0] tag, input logic [7:0] exp, input logic err);
    int n;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_fun = fun; bus.cmd_tag = tag; bus.cmd_valid = 1;
    tick;
    bus.cmd_valid = 0;
    n = 1;
    while (!bus.rsp_valid && n < 10) begin tick; n++; end
    chk("latency", n, err ? 1 : 3);
    chk("data", bus.rsp_data, exp);
    chk("tag", bus.rsp_tag, tag);
    chk("err", bus.rsp_err, err);
    tick;
    chk("ready_after", bus.cmd_ready, 1);
  endtask
  initial begin
    int n, acc, last, bad, seen, mx;
    bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_fun = 0; bus.cmd_tag = 0;
    bus.rsp_ready = 1;
    tick; tick;
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_fun}, 0);
    chk("rst_rsp", {bus.rsp_data, bus.rsp_tag, bus.rsp_err}, 0);
    chk("rst_cnt", {bus.op_count, bus.err_count}, 0);
    rst = 0;
    tick;
    chk("idle_ready", bus.cmd_ready, 1);
    // add with explicit cycle-by-cycle timeline
    bus.cmd_a = 9; bus.cmd_b = 7; bus.cmd_fun = 0; bus.cmd_tag = 3; bus.cmd_valid = 1;
    tick;
    bus.cmd_valid = 0;
    chk("add_alu", {bus.alu_a, bus.alu_b, bus.alu_fun}, {4'd9, 4'd7, 2'd0});
    chk("add_c1_busy", {bus.busy, bus.cmd_ready, bus.rsp_valid}, 3'b100);
    tick;
    chk("add_c2_valid", bus.rsp_valid, 0);
    tick;
    chk("add_c3_valid", bus.rsp_valid, 1);
    chk("add_data", bus.rsp_data, 8'h10);
    chk("add_tag", bus.rsp_tag, 3);
    chk("add_err", bus.rsp_err, 0);
    tick;
    chk("add_opcnt", bus.op_count, 1);
    chk("add_idle", {bus.cmd_ready, bus.rsp_valid, bus.busy}, 3'b100);
    run_op(3, 5, 1, 1, 8'hFE, 0);
    run_op(15, 15, 2, 2, 8'hE1, 0);
    run_op(14, 4, 3, 4, 8'h03, 0);
    run_op(6, 0, 3, 5, 8'hFF, 1);
    chk("div0_alu", {bus.alu_a, bus.alu_b, bus.alu_fun}, {4'd14, 4'd4, 2'd3});
    chk("div0_cnt", {bus.op_count, bus.err_count}, {8'd5, 8'd1});
    // backpressure: response must hold and new commands be ignored
    bus.rsp_ready = 0;
    bus.cmd_a = 2; bus.cmd_b = 3; bus.cmd_fun = 0; bus.cmd_tag = 7; bus.cmd_valid = 1;
    tick;
    bus.cmd_a = 8; bus.cmd_b = 8; bus.cmd_fun = 2; bus.cmd_tag = 9;
    n = 1;
    while (!bus.rsp_valid && n < 10) begin tick; n++; end
    chk("bp_latency", n, 3);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, 8'h05);
      chk("bp_tag", bus.rsp_tag, 7);
      chk("bp_ready", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 0;
    bus.rsp_ready = 1;
    tick;
    chk("bp_release", {bus.rsp_valid, bus.busy, bus.cmd_ready}, 3'b001);
    chk("bp_opcnt", bus.op_count, 6);
    chk("bp_alu_kept", bus.alu_a, 2);
    // reset while waiting on the ALU
    bus.cmd_a = 1; bus.cmd_b = 1; bus.cmd_fun = 0; bus.cmd_tag = 11; bus.cmd_valid = 1;
    tick;
    bus.cmd_valid = 0;
    tick;
    chk("mid_busy", {bus.busy, bus.rsp_valid}, 2'b10);
    rst = 1;
    tick;
    chk("mid_rst", {bus.rsp_valid, bus.busy, bus.cmd_ready}, 0);
    chk("mid_cnt", {bus.op_count, bus.err_count}, 0);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick; seen += int'(bus.rsp_valid); end
    chk("mid_no_rsp", seen, 0);
    chk("mid_ready", bus.cmd_ready, 1);
    // 256 back-to-back adds, accepts exactly four cycles apart
    bus.cmd_a = 1; bus.cmd_b = 1; bus.cmd_fun = 0; bus.cmd_tag = 1; bus.cmd_valid = 1;
    acc = 0; last = 0; bad = 0; mx = 0; n = 0;
    while (acc < 256 && n < 1200) begin
      if (bus.cmd_ready) begin
        if (acc > 0 && n - last != 4) bad++;
        last = n;
        acc++;
      end
      if (int'(bus.op_count) > mx) mx = int'(bus.op_count);
      tick;
      n++;
    end
    bus.cmd_valid = 0;
    chk("wrap_accepts", acc, 256);
    chk("wrap_spacing", bad, 0);
    n = 0;
    while (bus.busy && n < 10) begin
      if (int'(bus.op_count) > mx) mx = int'(bus.op_count);
      tick;
      n++;
    end
    chk("wrap_timeout", bus.busy, 0);
    chk("wrap_max", mx, 255);
    chk("wrap_opcnt", bus.op_count, 0);
    chk("wrap_errcnt", bus.err_count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
